// File: rtl/thermometer_decoder.sv
// rtl/thermometer_decoder.sv - two-stage thermometer-to-binary decoder with bubble correction
// S1 registers the code; S2 corrects, decodes and registers dout plus error flags.
module thermometer_decoder #(
   parameter int THERMO_WIDTH = 256,
   parameter int BIN_WIDTH    = $clog2(THERMO_WIDTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [THERMO_WIDTH-1:0] i_thermo,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   output logic [BIN_WIDTH-1:0]    o_dout,
   output logic                    o_err_bubble,
   output logic                    o_err_invalid,
   output logic                    o_out_valid,
   input  logic                    i_out_ready
);

   logic [THERMO_WIDTH-1:0] r_s1_thermo;
   logic                    r_s1_valid;
   logic                    r_s2_valid;
   logic [BIN_WIDTH-1:0]    r_dout;
   logic                    r_err_bubble;
   logic                    r_err_invalid;

   logic                    w_s2_load;
   logic                    w_in_xfer;
   logic [THERMO_WIDTH+1:0] w_ext;
   logic [THERMO_WIDTH-1:0] w_corr;
   logic [BIN_WIDTH-1:0]    w_dout;
   logic                    w_gap;
   logic                    w_bubble;
   logic                    w_invalid;

   assign w_s2_load  = r_s1_valid && (!r_s2_valid || i_out_ready);
   assign o_in_ready = !r_s1_valid || w_s2_load;
   assign w_in_xfer  = i_in_valid && o_in_ready;

   // Pad with an implicit 1 below bit 0 and 0 above the top bit before the majority vote.
   always_comb begin
      w_ext  = {1'b0, r_s1_thermo, 1'b1};
      w_corr = '0;
      w_dout = '0;
      w_gap  = 1'b0;
      for (int i = 0; i < THERMO_WIDTH; i++) begin
         w_corr[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) | (w_ext[i+1] & w_ext[i+2]);
      end
      for (int i = 0; i < THERMO_WIDTH; i++) begin
         if (w_corr[i]) w_dout = BIN_WIDTH'(i);
      end
      for (int i = 0; i < THERMO_WIDTH - 1; i++) begin
         if (!w_corr[i] && w_corr[i+1]) w_gap = 1'b1;
      end
   end

   assign w_bubble  = (w_corr != r_s1_thermo);
   assign w_invalid = !r_s1_thermo[0] || (w_corr == '0) || w_gap;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_thermo <= '0;
         r_s1_valid  <= 1'b0;
      end else begin
         if (w_in_xfer) r_s1_thermo <= i_thermo;
         r_s1_valid <= w_in_xfer || (r_s1_valid && !w_s2_load);
      end
   end

   // S2 only changes on a load, so outputs hold while stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s2_valid    <= 1'b0;
         r_dout        <= '0;
         r_err_bubble  <= 1'b0;
         r_err_invalid <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid    <= 1'b1;
         r_dout        <= w_dout;
         r_err_bubble  <= w_bubble;
         r_err_invalid <= w_invalid;
      end else if (i_out_ready) begin
         r_s2_valid    <= 1'b0;
      end
   end

   assign o_dout        = r_dout;
   assign o_err_bubble  = r_err_bubble;
   assign o_err_invalid = r_err_invalid;
   assign o_out_valid   = r_s2_valid;

endmodule

// File: tb/tb_thermometer_decoder.sv
// tb/tb_thermometer_decoder.sv - directed vector bench for thermometer_decoder (256 and 16 wide)
module tb_thermometer_decoder;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] thermo;
   logic         in_valid, in_ready, out_valid, out_ready, err_bubble, err_invalid;
   logic [7:0]   dout;
   logic [15:0]  thermo16;
   logic         in_valid16, in_ready16, out_valid16, out_ready16, err_bubble16, err_invalid16;
   logic [3:0]   dout16;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   thermometer_decoder #(.THERMO_WIDTH(256), .BIN_WIDTH(8)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_thermo(thermo), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .o_dout(dout), .o_err_bubble(err_bubble), .o_err_invalid(err_invalid),
      .o_out_valid(out_valid), .i_out_ready(out_ready));

   thermometer_decoder #(.THERMO_WIDTH(16), .BIN_WIDTH(4)) u_dut16 (
      .i_clk(clk), .i_rst(rst), .i_thermo(thermo16), .i_in_valid(in_valid16), .o_in_ready(in_ready16),
      .o_dout(dout16), .o_err_bubble(err_bubble16), .o_err_invalid(err_invalid16),
      .o_out_valid(out_valid16), .i_out_ready(out_ready16));

   typedef struct {
      logic [255:0] t;
      logic [7:0]   d;
      logic         b;
      logic         v;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [255:0] therm(input int v);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i <= v; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_one(input vec_t v, input int idx);
      @(negedge clk);
      in_valid  = 1'b1;
      thermo    = v.t;
      out_ready = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", idx), in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_out_valid", idx), out_valid, 1);
      check($sformatf("v%0d_dout", idx), dout, v.d);
      check($sformatf("v%0d_err_bubble", idx), err_bubble, v.b);
      check($sformatf("v%0d_err_invalid", idx), err_invalid, v.v);
   endtask

   task automatic apply16(input int v);
      logic [15:0] t;
      t = '0;
      for (int i = 0; i <= v; i++) t[i] = 1'b1;
      @(negedge clk);
      in_valid16 = 1'b1;
      thermo16   = t;
      @(posedge clk);
      @(negedge clk);
      in_valid16 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("w16_%0d_out_valid", v), out_valid16, 1);
      check($sformatf("w16_%0d_dout", v), dout16, v);
      check($sformatf("w16_%0d_errs", v), {err_bubble16, err_invalid16}, 0);
   endtask

   initial begin
      int next_in, next_out, cyc;
      logic stalled;
      logic [7:0] held;
      logic [255:0] t;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; thermo = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b1; thermo16 = '0;

      vecs[0] = '{therm(0), 8'd0, 1'b0, 1'b0};
      vecs[1] = '{therm(1), 8'd1, 1'b0, 1'b0};
      vecs[2] = '{therm(127), 8'd127, 1'b0, 1'b0};
      vecs[3] = '{therm(255), 8'd255, 1'b0, 1'b0};
      t = therm(100); t[50] = 1'b0;
      vecs[4] = '{t, 8'd100, 1'b1, 1'b0};
      t = therm(100); t[103] = 1'b1;
      vecs[5] = '{t, 8'd100, 1'b1, 1'b0};
      t = therm(100); t[101] = 1'b1;
      vecs[6] = '{t, 8'd101, 1'b0, 1'b0};
      vecs[7] = '{256'd0, 8'd0, 1'b0, 1'b1};
      t = therm(9); for (int i = 40; i <= 49; i++) t[i] = 1'b1;
      vecs[8] = '{t, 8'd49, 1'b0, 1'b1};
      t = therm(100); t[0] = 1'b0;
      vecs[9] = '{t, 8'd100, 1'b1, 1'b1};
      t = therm(100); t[50] = 1'b0; t[51] = 1'b0;
      vecs[10] = '{t, 8'd100, 1'b0, 1'b1};
      t = '0; t[255] = 1'b1;
      vecs[11] = '{t, 8'd0, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_errs", {err_bubble, err_invalid}, 0);
      check("rst_in_ready", in_ready, 1);

      // Back-to-back stream: output j appears two sample points after its input.
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (j < 4) begin
            in_valid = 1'b1;
            thermo   = vecs[j].t;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (j < 4) check($sformatf("t1_in_ready_%0d", j), in_ready, 1);
         if (j < 2) check($sformatf("t1_empty_%0d", j), out_valid, 0);
         else begin
            check($sformatf("t1_out_valid_%0d", j - 2), out_valid, 1);
            check($sformatf("t1_dout_%0d", j - 2), dout, vecs[j-2].d);
            check($sformatf("t1_errs_%0d", j - 2), {err_bubble, err_invalid}, 0);
         end
      end

      for (int k = 0; k < 12; k++) apply_one(vecs[k], k);

      // Fill both stages with out_ready low, then reset while full.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; thermo = therm(10);
      #1 check("fill_in_ready_0", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      thermo = therm(20);
      #1 check("fill_in_ready_1", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      thermo = therm(30);
      #1;
      check("full_in_ready", in_ready, 0);
      check("full_out_valid", out_valid, 1);
      check("full_dout", dout, 10);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("stall_dout", dout, 10);
      check("stall_in_ready", in_ready, 0);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_dout", dout, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         #1 check($sformatf("post_rst_no_stale_%0d", j), out_valid, 0);
      end
      apply_one('{therm(42), 8'd42, 1'b0, 1'b0}, 42);

      // Gapped input, random backpressure, full 0..255 stream.
      next_in = 0; next_out = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (next_out < 256 && cyc < 4000) begin
         @(negedge clk);
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (next_in < 256) && ($urandom_range(0, 3) != 0);
         thermo    = therm(next_in < 256 ? next_in : 0);
         #1;
         if (stalled) begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_dout", dout, held);
         end
         if (out_valid && out_ready) begin
            check("t4_order", dout, next_out[7:0]);
            next_out++;
         end
         stalled = out_valid && !out_ready;
         held    = dout;
         if (in_valid && in_ready) next_in++;
         cyc++;
      end
      check("t4_outputs", next_out, 256);
      check("t4_inputs", next_in, 256);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1 check("t4_no_extra", out_valid, 0);

      for (int v = 0; v < 16; v++) apply16(v);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
